// File: rtl/unsigned_seq_div_16x8.sv
// Restoring unsigned divider, 16-bit dividend by 8-bit divisor, one quotient bit per clock.
// Define UDIV_APPROX_EN to compute only quotient bits 15..TRUNC_L (approximate mode).
module unsigned_seq_div_16x8 #(
  parameter int TRUNC_L = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef UDIV_APPROX_EN
  localparam int TL = TRUNC_L;
`else
  localparam int TL = 0 * TRUNC_L;
`endif
  localparam int          ITER     = 16 - TL;
  localparam logic [3:0]  CNT_LOAD = 4'(ITER - 1);
  // Low dividend bits that are never shifted in are cleared at load.
  localparam logic [15:0] KEEP     = 16'hFFFF << TL;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] d;
  logic [15:0] q;
  logic [7:0]  r;
  logic [7:0]  dsr;
  logic [8:0]  r_shift;
  logic [7:0]  r_next;
  logic        q_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    r_shift = {r, d[15]};
    q_bit   = (r_shift >= {1'b0, dsr});
    r_next  = q_bit ? (r_shift[7:0] - dsr) : r_shift[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      d           <= '0;
      q           <= '0;
      r           <= '0;
      dsr         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              d     <= dividend & KEEP;
              dsr   <= divisor;
              r     <= '0;
              q     <= '0;
              cnt   <= CNT_LOAD;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          d <= {d[14:0], 1'b0};
          r <= r_next;
          q <= {q[14:0], q_bit};
          if (cnt == '0) begin
            quotient    <= {q[14:0], q_bit} << TL;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
